// File: rtl/clk_div_mon_if.sv
// Signal bundle between the divided-clock monitor and its environment.
// The environment drives clk_div/err_clr; the monitor drives the measurement and status outputs.
interface clk_div_mon_if;
  logic       clk_div;
  logic       err_clr;
  logic [7:0] period;
  logic [7:0] high_cnt;
  logic       meas_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic       stall;

  modport master (
    output clk_div, err_clr,
    input  period, high_cnt, meas_valid, locked, err, err_cnt, stall
  );

  modport slave (
    input  clk_div, err_clr,
    output period, high_cnt, meas_valid, locked, err, err_cnt, stall
  );
endinterface

// File: rtl/clk_div_mon.sv
// Measures period and high time of an asynchronous divided clock, judges lock
// against an expected period, and flags period errors and stalls.
module clk_div_mon #(
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int STALL_MAX  = 255
) (
  input  logic         clk_in,
  input  logic         rst,
  clk_div_mon_if.slave mon
);
  localparam logic [7:0] STALL_MAX_B = 8'(STALL_MAX);
  localparam logic [3:0] LOCK_CNT_B  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_s1, r_s2, r_s3;
  logic [7:0] r_per_cnt, r_hi_acc;
  logic [7:0] r_period, r_high_cnt, r_err_cnt;
  logic [3:0] r_good_run;
  logic       r_meas_valid, r_err, r_stall;

  logic       w_rise, w_meas, w_good, w_bad_lock, w_stall_evt, w_err_evt;
  logic [3:0] w_good_run_inc;
  int         w_diff;

  always_comb begin
    w_rise         = r_s2 & ~r_s3;
    w_diff         = int'({24'd0, r_per_cnt}) - EXP_PERIOD;
    w_good         = (w_diff <= TOL) && (w_diff >= -TOL) &&
                     (r_hi_acc != 8'd0) && (r_hi_acc < r_per_cnt);
    w_good_run_inc = (r_good_run == 4'hF) ? r_good_run : r_good_run + 4'd1;
    w_meas         = w_rise && (r_state != S_IDLE);
    // A rise coincident with the timeout is a valid edge, so it suppresses the stall.
    w_stall_evt    = !w_rise && (r_state != S_IDLE) && (r_per_cnt == STALL_MAX_B);
    w_bad_lock     = w_meas && !w_good && (r_state == S_LOCK);
    w_err_evt      = w_bad_lock || w_stall_evt;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_next = S_ACQ;
      end
      S_ACQ: begin
        if (w_stall_evt)
          w_state_next = S_IDLE;
        else if (w_meas && w_good && (w_good_run_inc >= LOCK_CNT_B))
          w_state_next = S_LOCK;
      end
      S_LOCK: begin
        if (w_stall_evt)     w_state_next = S_IDLE;
        else if (w_bad_lock) w_state_next = S_ACQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_per_cnt    <= 8'd0;
      r_hi_acc     <= 8'd0;
      r_period     <= 8'd0;
      r_high_cnt   <= 8'd0;
      r_meas_valid <= 1'b0;
      r_good_run   <= 4'd0;
      r_stall      <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_s1 <= mon.clk_div;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_rise)                    r_per_cnt <= 8'd1;
      else if (r_per_cnt != 8'hFF)   r_per_cnt <= r_per_cnt + 8'd1;

      // The rise cycle itself is a high sample, hence the reload value of 1.
      if (w_rise)                          r_hi_acc <= 8'd1;
      else if (r_s2 && r_hi_acc != 8'hFF)  r_hi_acc <= r_hi_acc + 8'd1;

      r_meas_valid <= w_meas;
      if (w_meas) begin
        r_period   <= r_per_cnt;
        r_high_cnt <= r_hi_acc;
      end

      if (w_stall_evt)  r_good_run <= 4'd0;
      else if (w_meas)  r_good_run <= w_good ? w_good_run_inc : 4'd0;

      if (w_stall_evt)  r_stall <= 1'b1;
      else if (w_rise)  r_stall <= 1'b0;

      // An error event in the same cycle as err_clr restarts the count at one.
      if (w_err_evt) begin
        r_err     <= 1'b1;
        r_err_cnt <= mon.err_clr ? 8'd1 :
                     (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
      end else if (mon.err_clr) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end
    end
  end

  assign mon.period     = r_period;
  assign mon.high_cnt   = r_high_cnt;
  assign mon.meas_valid = r_meas_valid;
  assign mon.locked     = (r_state == S_LOCK);
  assign mon.err        = r_err;
  assign mon.err_cnt    = r_err_cnt;
  assign mon.stall      = r_stall;
endmodule
